// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA timing sink: recovers x/y from hsync/vsync/blank, checks timing, reports lock
// Optional saturating error counter enabled by defining VGA_SYNC_ERR_CNT_EN.
module vga_sync_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 521,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       active,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [7:0] err_count
);

    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HSS = 10'(H_SYNC_START);
    localparam logic [9:0] HSR = 10'(H_SYNC_END + 1);
    localparam logic [9:0] HTL = 10'(H_TOTAL - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VSS = 10'(V_SYNC_START);
    localparam logic [9:0] VTL = 10'(V_TOTAL - 1);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    // Timing must nest inside the 10-bit coordinate space with sync pulses after the active area.
    if (!(H_ACTIVE <= H_SYNC_START && H_SYNC_START <= H_SYNC_END && H_SYNC_END + 1 < H_TOTAL &&
          H_TOTAL <= 1024 && V_ACTIVE <= V_SYNC_START && V_SYNC_START <= V_SYNC_END &&
          V_SYNC_END < V_TOTAL && V_TOTAL <= 1024 && LOCK_FRAMES >= 1 && LOCK_FRAMES < 255)) begin : g_bad_params
        $error("vga_sync_decoder: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t     state, next_state;
    logic [7:0] good, next_good;
    logic       hs_prev, vs_prev;
    logic [9:0] px_pred, py_pred, nx, ny;
    logic       hs_fall, hs_rise, vs_fall;
    logic       checking, vs_match, visible;
    logic       err_a, err_b, err_c, err_d, err_other, err_any;

    always_comb begin
        px_pred = (pixel_x == HTL) ? 10'd0 : pixel_x + 10'd1;
        py_pred = pixel_y;
        if (px_pred == 10'd0) begin
            py_pred = (pixel_y == VTL) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    assign hs_fall  = hs_prev & ~hsync;
    assign hs_rise  = ~hs_prev & hsync;
    assign vs_fall  = vs_prev & ~vsync;
    assign checking = (state != HUNT);
    assign vs_match = (px_pred == 10'd0) && (py_pred == VSS);
    assign visible  = (px_pred < HA) && (py_pred < VA);

    assign err_a     = checking & (hs_fall != (px_pred == HSS));
    assign err_b     = checking & ((hs_rise & (px_pred != HSR)) | ((px_pred == HSR) & ~hsync));
    assign err_c     = checking & (vs_fall != vs_match);
    assign err_d     = checking & (blank != visible);
    assign err_other = err_a | err_b | err_d;
    assign err_any   = err_other | err_c;

    // A vsync fall re-anchors both counters; hsync only re-anchors x once we are tracking.
    always_comb begin
        nx = px_pred;
        ny = py_pred;
        if (vs_fall) begin
            nx = 10'd0;
            ny = VSS;
        end else if (hs_fall && checking) begin
            nx = HSS;
        end
    end

    always_comb begin
        next_state = state;
        next_good  = good;
        case (state)
            HUNT: begin
                if (vs_fall) begin
                    next_state = VERIFY;
                    next_good  = 8'd0;
                end
            end
            VERIFY, LOCKED: begin
                if (err_other) begin
                    next_state = HUNT;
                    next_good  = 8'd0;
                end else if (err_c) begin
                    next_state = VERIFY;
                    next_good  = 8'd0;
                end else if (state == VERIFY && vs_fall) begin
                    next_good = good + 8'd1;
                    if (good + 8'd1 >= LOCK_N) begin
                        next_state = LOCKED;
                    end
                end
            end
            default: begin
                next_state = HUNT;
                next_good  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            good        <= 8'd0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= next_state;
            good        <= next_good;
            hs_prev     <= hsync;
            vs_prev     <= vsync;
            pixel_x     <= nx;
            pixel_y     <= ny;
            active      <= (next_state == LOCKED) && (nx < HA) && (ny < VA);
            frame_start <= (next_state != HUNT) && (nx == 10'd0) && (ny == 10'd0);
            locked      <= (next_state == LOCKED);
            sync_err    <= err_any;
        end
    end

`ifdef VGA_SYNC_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_any && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a scaled-down timing
module tb_vga_sync_decoder;

    localparam int HA = 16, HSS = 18, HSE = 21, HT = 24;
    localparam int VA = 10, VSS = 12, VSE = 13, VT = 15;
    localparam int LOCK = 2;
    localparam int FRAME = HT * VT;
`ifdef VGA_SYNC_ERR_CNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync = 1'b1, vsync = 1'b1, blank = 1'b0;
    logic [9:0] pixel_x, pixel_y;
    logic       active, frame_start, locked, sync_err;
    logic [7:0] err_count;
    logic [31:0] outs;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .active(active), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;
    assign outs = {pixel_x, pixel_y, active, frame_start, locked, sync_err, err_count};

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    bit skip_wait = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("outputs{x,y,act,fs,lock,err,cnt}", outs, e);
        end
    end

    // Reference model: coordinates as plain integers, mode 0=hunt 1=verify 2=locked.
    int m_x, m_y, m_mode, m_good, m_cnt;
    bit m_hp, m_vp;
    logic [31:0] m_out;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_mode = 0; m_good = 0; m_cnt = 0; m_hp = 1; m_vp = 1;
    endtask

    task automatic model_step(input bit hs, input bit vs, input bit bl);
        int px, py, nx, ny;
        bit hf, hr, vf, bad_v, bad_other, err, act, fs;
        px = (m_x + 1) % HT;
        py = (px == 0) ? (m_y + 1) % VT : m_y;
        hf = m_hp && !hs;
        hr = !m_hp && hs;
        vf = m_vp && !vs;
        bad_v = 0;
        bad_other = 0;
        if (m_mode != 0) begin
            bad_other = (hf != (px == HSS)) || (hr && px != HSE + 1) || (px == HSE + 1 && !hs)
                        || (bl != (px < HA && py < VA));
            bad_v = (vf != (px == 0 && py == VSS));
        end
        err = bad_other || bad_v;
        nx = px; ny = py;
        if (vf) begin nx = 0; ny = VSS; end
        else if (hf && m_mode != 0) nx = HSS;
        if (m_mode == 0) begin
            if (vf) begin m_mode = 1; m_good = 0; end
        end else if (bad_other) m_mode = 0;
        else if (bad_v) begin m_mode = 1; m_good = 0; end
        else if (m_mode == 1 && vf) begin
            m_good++;
            if (m_good >= LOCK) m_mode = 2;
        end
        if (ERR_ON && err && m_cnt < 255) m_cnt++;
        m_x = nx; m_y = ny; m_hp = hs; m_vp = vs;
        act = (m_mode == 2) && nx < HA && ny < VA;
        fs = (m_mode != 0) && nx == 0 && ny == 0;
        m_out = {10'(nx), 10'(ny), act, fs, (m_mode == 2), err, 8'(m_cnt)};
    endtask

    task automatic drive(input bit hs, input bit vs, input bit bl);
        if (!skip_wait) @(negedge clk);
        skip_wait = 1'b0;
        hsync = hs; vsync = vs; blank = bl;
        model_step(hs, vs, bl);
        exp_q.push_back(m_out);
    endtask

    // Ideal timing source; kind 1 delays hsync fall, 2 inverts blank, 3 fires vsync early.
    int gx, gy;
    task automatic gen_step(input int kind);
        bit hs, vs, bl;
        hs = !(gx >= HSS && gx <= HSE);
        vs = !(gy >= VSS && gy <= VSE);
        bl = (gx < HA && gy < VA);
        if (kind == 1) hs = 1;
        if (kind == 2) bl = !bl;
        if (kind == 3) vs = 0;
        drive(hs, vs, bl);
        if (kind == 3) begin
            gx = 1; gy = VSS;
        end else begin
            gx++;
            if (gx == HT) begin gx = 0; gy = (gy + 1) % VT; end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) gen_step(0);
        settle();
    endtask

    task automatic run_until(input int kx, input int ky, input int kind);
        int guard;
        guard = 0;
        while (!(gx == kx && gy == ky) && guard < 2 * FRAME) begin
            gen_step(0);
            guard++;
        end
        if (guard >= 2 * FRAME) check("run_until_bound", 32'(guard), 32'(2 * FRAME - 1));
        else gen_step(kind);
        settle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; hsync = 1; vsync = 1; blank = 0;
        model_reset();
        gx = 0; gy = 0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", outs, 32'h0);
        @(negedge clk);
        rst = 0;
        skip_wait = 1'b1;
    endtask

    int exp_errs = 0;

    initial begin
        int ly, bx, by, ey;
        model_reset();
        gx = 0; gy = 0;
        do_reset();

        // Ideal timing: lock follows the third vsync fall.
        run_until(0, VSS, 0);
        run_until(0, VSS, 0);
        check("not_locked_before_3rd_fall", 32'(locked), 32'd0);
        run_until(0, VSS, 0);
        check("locked_after_3rd_fall", 32'(locked), 32'd1);
        check("coords_at_lock", {22'd0, pixel_x}, 32'd0);
        run_cycles(FRAME);

        // Delayed hsync fall: error on the missing edge, back to hunt.
        ly = $urandom_range(0, VT - 1);
        run_until(HSS, ly, 1);
        exp_errs++;
        check("hs_delay_err", 32'(sync_err), 32'd1);
        check("hs_delay_unlock", 32'(locked), 32'd0);
        check("hs_delay_cnt", 32'(err_count), ERR_ON ? 32'(exp_errs) : 32'd0);
        run_cycles(4 * FRAME);
        check("relock_after_hs", 32'(locked), 32'd1);

        // Blank glitches inside the active area.
        for (int i = 0; i < 3; i++) begin
            bx = $urandom_range(0, HA - 1);
            by = $urandom_range(0, VA - 1);
            run_until(bx, by, 2);
            exp_errs++;
            check("blank_err", 32'(sync_err), 32'd1);
            check("blank_unlock", 32'(locked), 32'd0);
            check("blank_cnt", 32'(err_count), ERR_ON ? 32'(exp_errs) : 32'd0);
            run_cycles(4 * FRAME);
            check("relock_after_blank", 32'(locked), 32'd1);
        end

        // Early vsync: reload to the sync line, verify, relock after two frames.
        ey = $urandom_range(1, VA - 1);
        run_until(0, ey, 3);
        check("early_vs_err", 32'(sync_err), 32'd1);
        check("early_vs_unlock", 32'(locked), 32'd0);
        check("early_vs_y", {22'd0, pixel_y}, 32'(VSS));
        check("early_vs_x", {22'd0, pixel_x}, 32'd0);
        for (int i = 0; i < 2 * FRAME - 1; i++) gen_step(0);
        settle();
        check("early_vs_still_unlocked", 32'(locked), 32'd0);
        gen_step(0);
        settle();
        check("early_vs_relock", 32'(locked), 32'd1);

        // Rapid mistimed vsync falls saturate the error counter.
        for (int i = 0; i < 600; i++) drive(1'b1, i[0], 1'b0);
        settle();
        check("err_count_saturated", 32'(err_count), ERR_ON ? 32'hFF : 32'd0);

        // Mid-line reset clears outputs at once; hsync alone never locks.
        do_reset();
        run_until(10, 3, 0);
        #3;
        rst = 1;
        #1;
        check("async_reset_outputs", outs, 32'h0);
        model_reset();
        gx = 0; gy = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        skip_wait = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            drive(!((i % HT) >= HSS && (i % HT) <= HSE), 1'b1, 1'b0);
        end
        settle();
        check("hsync_only_no_lock", 32'(locked), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
